// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//   Bundles the writeback and register-read signals of wb_regfile.
//   Parameter WIDTH sets the width of the datapath fields.
//
//   Writeback side (from the MEM/WB pipeline register):
//     IRegWrite    writeback enable
//     IRegStore    source select: 1 = IStoreMem, 0 = IALUResult
//     IALUResult   ALU result
//     IStoreMem    memory load data
//     IRd          destination field; only bits [3:0] matter
//   Read side (from decode):
//     IRs1, IRs2   read-port indices
//     ORd1, ORd2   read-port data
//   Status:
//     OWBData      selected writeback value
//     OWBActive    a write commits this cycle
//     ORetireCount number of committed writes (wraps at 16 bits)
//
//   There is no valid/ready pair on this bus. A writeback is offered by
//   holding IRegWrite high across a rising edge. It is always accepted in
//   that cycle, and the slave cannot stall it.
interface wb_regfile_if #(
    parameter int WIDTH = 16
);
    logic             IRegWrite;
    logic             IRegStore;
    logic [WIDTH-1:0] IALUResult;
    logic [WIDTH-1:0] IStoreMem;
    logic [WIDTH-1:0] IRd;
    logic [3:0]       IRs1;
    logic [3:0]       IRs2;
    logic [WIDTH-1:0] ORd1;
    logic [WIDTH-1:0] ORd2;
    logic [WIDTH-1:0] OWBData;
    logic             OWBActive;
    logic [15:0]      ORetireCount;

    modport master (
        output IRegWrite, IRegStore, IALUResult, IStoreMem, IRd, IRs1, IRs2,
        input  ORd1, ORd2, OWBData, OWBActive, ORetireCount
    );

    modport slave (
        input  IRegWrite, IRegStore, IALUResult, IStoreMem, IRd, IRs1, IRs2,
        output ORd1, ORd2, OWBData, OWBActive, ORetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
//   Register file with a writeback stage. It has two combinational read
//   ports with write-through bypass, and it counts retired writes.
//   Register 0 is hard-wired to zero.
//
//   Ports:
//     clk    single clock; all state changes on the rising edge
//     reset  synchronous, active-high; clears the registers and the counter
//     bus    wb_regfile_if.slave (see the interface for the signal list)
module wb_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic          clk,
    input  logic          reset,
    wb_regfile_if.slave   bus
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [15:0]      retireCount;
    logic [WIDTH-1:0] wbData;
    logic [3:0]       rdIdx;
    logic             wbActive;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Only the low nibble of IRd selects a register. The rest of the field
    // is deliberately ignored.
    logic unusedRdHigh;
    assign unusedRdHigh = ^bus.IRd[WIDTH-1:4];

    assign rdIdx  = bus.IRd[3:0];
    assign wbData = bus.IRegStore ? bus.IStoreMem : bus.IALUResult;

    // Writes to index 0 are dropped. Reset suppresses the commit, and
    // because the bypass keys off this signal, it suppresses the bypass too.
    assign wbActive = bus.IRegWrite && (rdIdx != 4'd0) && !reset;

    // When the write target is also being read, the read port returns the
    // value being written in the same cycle. Indices outside NREGS read
    // as zero.
    always_comb begin
        rd1 = '0;
        if (wbActive && (bus.IRs1 == rdIdx)) begin
            rd1 = wbData;
        end else if ((bus.IRs1 != 4'd0) && (int'(bus.IRs1) < NREGS)) begin
            rd1 = regs[bus.IRs1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (wbActive && (bus.IRs2 == rdIdx)) begin
            rd2 = wbData;
        end else if ((bus.IRs2 != 4'd0) && (int'(bus.IRs2) < NREGS)) begin
            rd2 = regs[bus.IRs2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            retireCount <= '0;
        end else if (wbActive) begin
            if (int'(rdIdx) < NREGS) begin
                regs[rdIdx] <= wbData;
            end
            // The counter wraps naturally at 16 bits.
            retireCount <= retireCount + 16'd1;
        end
    end

    assign bus.ORd1         = rd1;
    assign bus.ORd2         = rd2;
    assign bus.OWBData      = wbData;
    assign bus.OWBActive    = wbActive;
    assign bus.ORetireCount = retireCount;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//   Self-checking bench for wb_regfile. It keeps a reference model made of
//   an array of register values and a retire counter, and checks the
//   directed scenarios and randomized traffic against that model.
module tb_wb_regfile;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_regfile_if #(.WIDTH(WIDTH)) bus ();

    wb_regfile #(.WIDTH(WIDTH), .NREGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] modelRegs [16];
    logic [15:0]      modelCount;

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] modelWb();
        return bus.IRegStore ? bus.IStoreMem : bus.IALUResult;
    endfunction

    function automatic logic modelActive();
        return (reset == 1'b0) && bus.IRegWrite && (bus.IRd[3:0] != 4'd0);
    endfunction

    function automatic logic [WIDTH-1:0] modelRead(input logic [3:0] idx);
        if (modelActive() && idx == bus.IRd[3:0]) return modelWb();
        if (idx == 4'd0) return '0;
        return modelRegs[idx];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic st, input logic [WIDTH-1:0] alu,
                         input logic [WIDTH-1:0] mem, input logic [WIDTH-1:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        bus.IRegWrite  = w;
        bus.IRegStore  = st;
        bus.IALUResult = alu;
        bus.IStoreMem  = mem;
        bus.IRd        = rd;
        bus.IRs1       = rs1;
        bus.IRs2       = rs2;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    // Outputs are sampled 1 time unit after the edge.
    task automatic clockEdge();
        logic             act;
        logic [WIDTH-1:0] wb;
        logic [3:0]       idx;
        act = modelActive();
        wb  = modelWb();
        idx = bus.IRd[3:0];
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) modelRegs[i] = '0;
            modelCount = '0;
        end else if (act) begin
            modelRegs[idx] = wb;
            modelCount     = modelCount + 16'd1;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, 4'd0, 4'd0);
        clockEdge();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.IRs1 = 4'(i);
            bus.IRs2 = 4'(15 - i);
            #1;
            checks++;
            if (bus.ORd1 !== 16'h0000 || bus.ORd2 !== 16'h0000) begin
                failures++;
                $display("FAIL reset_read idx=%0d: ORd1=%h ORd2=%h expected 0000", i, bus.ORd1, bus.ORd2);
            end
        end
        checks++;
        if (bus.ORetireCount !== 16'h0000) begin
            failures++;
            $display("FAIL reset_count: got %h expected 0000", bus.ORetireCount);
        end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b0, 16'h1234, 16'h5555, 16'h0005, 4'd0, 4'd0);
        #1;
        checks++;
        if (bus.OWBData !== 16'h1234 || bus.OWBActive !== 1'b1) begin
            failures++;
            $display("FAIL alu_wb: OWBData=%h OWBActive=%b expected 1234/1", bus.OWBData, bus.OWBActive);
        end
        clockEdge();
        drive(1'b0, 1'b0, '0, '0, '0, 4'd5, 4'd0);
        #1;
        checks++;
        if (bus.ORd1 !== 16'h1234) begin
            failures++;
            $display("FAIL alu_read: ORd1=%h expected 1234", bus.ORd1);
        end
        checks++;
        if (bus.ORetireCount !== 16'd1) begin
            failures++;
            $display("FAIL alu_count: got %0d expected 1", bus.ORetireCount);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 16'h1111, 16'hBEEF, 16'hFFF3, 4'd3, 4'd3);
        #1;
        checks++;
        if (bus.ORd1 !== 16'hBEEF || bus.ORd2 !== 16'hBEEF || bus.OWBData !== 16'hBEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle: ORd1=%h ORd2=%h OWBData=%h expected BEEF", bus.ORd1, bus.ORd2, bus.OWBData);
        end
        clockEdge();
        bus.IRegWrite = 1'b0;
        #1;
        checks++;
        if (bus.ORd1 !== 16'hBEEF || bus.ORetireCount !== 16'd2) begin
            failures++;
            $display("FAIL bypass_stored: ORd1=%h count=%0d expected BEEF/2", bus.ORd1, bus.ORetireCount);
        end
    endtask

    task automatic test_zero_write();
        // Index 0 is selected both directly and through a nonzero upper field.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, (k == 0) ? 16'h0000 : 16'hABC0, 4'd0, 4'd0);
            #1;
            checks++;
            if (bus.OWBActive !== 1'b0 || bus.ORd1 !== 16'h0000 || bus.OWBData !== 16'hFFFF) begin
                failures++;
                $display("FAIL zero_write_comb k=%0d: active=%b ORd1=%h OWBData=%h expected 0/0000/FFFF", k, bus.OWBActive, bus.ORd1, bus.OWBData);
            end
            clockEdge();
            checks++;
            if (bus.ORd1 !== 16'h0000 || bus.ORetireCount !== 16'd2) begin
                failures++;
                $display("FAIL zero_write_after k=%0d: ORd1=%h count=%0d expected 0000/2", k, bus.ORd1, bus.ORetireCount);
            end
        end
        bus.IRegWrite = 1'b0;
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0007, 4'd7, 4'd7);
        clockEdge();
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h00AA, 16'h0000, 16'h0007, 4'd7, 4'd7);
        #1;
        checks++;
        if (bus.OWBActive !== 1'b0 || bus.ORd1 !== 16'h7777 || bus.ORd2 !== 16'h7777) begin
            failures++;
            $display("FAIL reset_no_bypass: active=%b ORd1=%h ORd2=%h expected 0/7777/7777", bus.OWBActive, bus.ORd1, bus.ORd2);
        end
        clockEdge();
        #1;
        checks++;
        if (bus.ORd1 !== 16'h0000 || bus.ORetireCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_priority: ORd1=%h count=%0d expected 0000/0", bus.ORd1, bus.ORetireCount);
        end
        // The first edge after reset deasserts commits normally.
        reset = 1'b0;
        clockEdge();
        bus.IRegWrite = 1'b0;
        #1;
        checks++;
        if (bus.ORd1 !== 16'h00AA || bus.ORetireCount !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_write: ORd1=%h count=%0d expected 00AA/1", bus.ORd1, bus.ORetireCount);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] rd;
        logic [3:0]       rs1;
        logic [3:0]       rs2;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            rd    = WIDTH'($urandom);
            rs1   = ($urandom_range(0, 2) == 0) ? rd[3:0] : 4'($urandom_range(0, 15));
            rs2   = ($urandom_range(0, 2) == 0) ? rd[3:0] : 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  WIDTH'($urandom), WIDTH'($urandom), rd, rs1, rs2);
            #1;
            checks++;
            if (bus.OWBData !== modelWb() || bus.OWBActive !== modelActive()) begin
                failures++;
                $display("FAIL random_wb n=%0d: OWBData=%h active=%b expected %h/%b", n, bus.OWBData, bus.OWBActive, modelWb(), modelActive());
            end
            checks++;
            if (bus.ORd1 !== modelRead(rs1) || bus.ORd2 !== modelRead(rs2)) begin
                failures++;
                $display("FAIL random_read n=%0d rs1=%0d rs2=%0d: ORd1=%h ORd2=%h expected %h/%h", n, rs1, rs2, bus.ORd1, bus.ORd2, modelRead(rs1), modelRead(rs2));
            end
            checks++;
            if (bus.ORetireCount !== modelCount) begin
                failures++;
                $display("FAIL random_count n=%0d: got %0d expected %0d", n, bus.ORetireCount, modelCount);
            end
            clockEdge();
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] last;
        reset = 1'b1;
        bus.IRegWrite = 1'b0;
        clockEdge();
        reset = 1'b0;
        last = '0;
        for (int n = 0; n < 65536; n++) begin
            last = WIDTH'($urandom);
            // The upper IRd bits vary while the index stays at 1.
            drive(1'b1, 1'($urandom_range(0, 1)), last, last, {12'($urandom), 4'd1}, 4'd1, 4'd2);
            clockEdge();
            if (n == 65534) begin
                checks++;
                if (bus.ORetireCount !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL wrap_max: got %h expected FFFF", bus.ORetireCount);
                end
            end
        end
        bus.IRegWrite = 1'b0;
        #1;
        checks++;
        if (bus.ORetireCount !== 16'h0000 || bus.ORetireCount !== modelCount) begin
            failures++;
            $display("FAIL wrap_zero: got %h expected 0000", bus.ORetireCount);
        end
        checks++;
        if (bus.ORd1 !== last || bus.ORd2 !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_reg1: ORd1=%h ORd2=%h expected %h/0000", bus.ORd1, bus.ORd2, last);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 16; i++) modelRegs[i] = '0;
        modelCount = '0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_alu_write();
        test_bypass();
        test_zero_write();
        test_reset_priority();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
